ecc_dec_pipe: RTL

ECC_DEC_PIPE -- requirements
Module: ecc_dec_pipe

---
 rtl/ecc_dec_pipe.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/ecc_dec_pipe.sv
// ecc_dec_pipe -- two-stage pipelined extended-Hamming (SECDED) decoder.
//
// Stage 1 registers the received codeword together with its Hamming syndrome
// and overall parity. Stage 2 classifies the error, corrects a single-bit
// error when possible, extracts the information bits and registers the result.
// Both stages use a valid/ready handshake so that one codeword per cycle can
// be sustained, and stalls never drop or duplicate a result.
//
// Parameters:
//   K       information bits (n = m + K, m = smallest with 2^m >= m+K+1)
//   P0_LSB  1: extended parity p0 at codeword bit 0, positions 1..n at bits 1..n
//           0: p0 at codeword bit n, positions 1..n at bits 0..n-1
//
// Ports:
//   clk_i, rst_ni           clock (rising edge), asynchronous active-low reset
//   s_valid_i/s_ready_o     codeword handshake, s_cw_i [n:0] codeword
//   m_valid_o/m_ready_i     result handshake
//   m_d_o [K-1:0]           decoded (corrected when possible) data
//   m_sb_err_o/m_db_err_o   single-bit corrected / double-bit uncorrectable
//   m_syndrome_o [m-1:0]    Hamming syndrome of the result
//   clr_cnt_i               synchronous clear of counters (and error log)
//   sb_cnt_o/db_cnt_o       saturating 16-bit error counters
//
// Optional feature, macro ECC_DEC_ERR_LOG_EN:
//   log_valid_o, log_syndrome_o [m-1:0] capture the syndrome of the first
//   double-bit error delivered at the output; held until clr_cnt_i.

module ecc_dec_pipe #(
  parameter int K      = 8,
  parameter int P0_LSB = 1,
  // m found by iterating m = clog2(K+1+m) from below; three steps converge
  localparam int M0 = $clog2(K + 1),
  localparam int M1 = $clog2(K + 1 + M0),
  localparam int M  = $clog2(K + 1 + M1),
  localparam int N  = M + K
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [N:0]   s_cw_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [K-1:0] m_d_o,
  output logic         m_sb_err_o,
  output logic         m_db_err_o,
  output logic [M-1:0] m_syndrome_o,
  input  logic         clr_cnt_i,
  output logic [15:0]  sb_cnt_o,
  output logic [15:0]  db_cnt_o
`ifdef ECC_DEC_ERR_LOG_EN
  ,
  output logic         log_valid_o,
  output logic [M-1:0] log_syndrome_o
`endif
);

  // Position of data bit idx: the idx-th non-power-of-2 position (1-based).
  function automatic int data_pos(input int idx);
    int cnt;
    int pos;
    cnt = -1;
    pos = 0;
    for (int j = 1; j <= N; j++) begin
      if ((j & (j - 1)) != 0) begin
        cnt++;
        if (cnt == idx && pos == 0) pos = j;
      end
    end
    return pos;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage 1: position vector, syndrome and overall parity
  // ---------------------------------------------------------------------------
  logic [N:1]   pos_vec;
  logic [M-1:0] syn_next;
  logic         par_next;

  for (genvar gi = 1; gi <= N; gi++) begin : g_pos
    assign pos_vec[gi] = s_cw_i[(P0_LSB != 0) ? gi : gi - 1];
  end

  for (genvar gi = 0; gi < M; gi++) begin : g_syn
    logic [N:1] mask;
    for (genvar gj = 1; gj <= N; gj++) begin : g_mask
      assign mask[gj] = (((gj >> gi) & 1) != 0);
    end
    assign syn_next[gi] = ^(pos_vec & mask);
  end

  // p0 is included here, so this is the parity of the whole n+1 bit word
  assign par_next = ^s_cw_i;

  logic         v1_reg;
  logic [N:1]   cw1_reg;
  logic [M-1:0] syn1_reg;
  logic         par1_reg;

  logic         v2_reg;
  logic         adv1;
  logic         adv2;

  // Stage 2 can load when empty or when its result leaves this cycle;
  // stage 1 can load when empty or when it moves into stage 2.
  assign adv2      = !v2_reg || m_ready_i;
  assign adv1      = !v1_reg || adv2;
  assign s_ready_o = adv1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_reg   <= 1'b0;
      cw1_reg  <= '0;
      syn1_reg <= '0;
      par1_reg <= 1'b0;
    end else if (adv1) begin
      v1_reg <= s_valid_i;
      if (s_valid_i) begin
        cw1_reg  <= pos_vec;
        syn1_reg <= syn_next;
        par1_reg <= par_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: classify, correct, extract
  // ---------------------------------------------------------------------------
  logic         sb_next;
  logic         db_next;
  logic         do_flip;
  logic [N:1]   fixed_vec;
  logic [K-1:0] d_next;

  always_comb begin
    sb_next = 1'b0;
    db_next = 1'b0;
    do_flip = 1'b0;
    if (par1_reg) begin
      if (syn1_reg == '0) begin
        // only p0 is wrong; data is already good
        sb_next = 1'b1;
      end else if (int'(syn1_reg) <= N) begin
        sb_next = 1'b1;
        do_flip = 1'b1;
      end else begin
        // odd parity but syndrome points outside the word: at least 3 errors
        db_next = 1'b1;
      end
    end else if (syn1_reg != '0) begin
      db_next = 1'b1;
    end
  end

  for (genvar gi = 1; gi <= N; gi++) begin : g_fix
    assign fixed_vec[gi] = cw1_reg[gi] ^ (do_flip && (syn1_reg == M'(gi)));
  end

  for (genvar gi = 0; gi < K; gi++) begin : g_dat
    localparam int DP = data_pos(gi);
    assign d_next[gi] = fixed_vec[DP];
  end

  logic [K-1:0] d2_reg;
  logic         sb2_reg;
  logic         db2_reg;
  logic [M-1:0] syn2_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v2_reg   <= 1'b0;
      d2_reg   <= '0;
      sb2_reg  <= 1'b0;
      db2_reg  <= 1'b0;
      syn2_reg <= '0;
    end else if (adv2) begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        d2_reg   <= d_next;
        sb2_reg  <= sb_next;
        db2_reg  <= db_next;
        syn2_reg <= syn1_reg;
      end
    end
  end

  assign m_valid_o    = v2_reg;
  assign m_d_o        = d2_reg;
  assign m_sb_err_o   = sb2_reg;
  assign m_db_err_o   = db2_reg;
  assign m_syndrome_o = syn2_reg;

  // ---------------------------------------------------------------------------
  // Error counters: count on output handshake, saturate, clear has priority
  // ---------------------------------------------------------------------------
  logic        out_hs;
  logic [15:0] sb_cnt_reg;
  logic [15:0] db_cnt_reg;

  assign out_hs = v2_reg && m_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb_cnt_reg <= '0;
      db_cnt_reg <= '0;
    end else if (clr_cnt_i) begin
      sb_cnt_reg <= '0;
      db_cnt_reg <= '0;
    end else if (out_hs) begin
      if (sb2_reg && sb_cnt_reg != 16'hFFFF) sb_cnt_reg <= sb_cnt_reg + 16'd1;
      if (db2_reg && db_cnt_reg != 16'hFFFF) db_cnt_reg <= db_cnt_reg + 16'd1;
    end
  end

  assign sb_cnt_o = sb_cnt_reg;
  assign db_cnt_o = db_cnt_reg;

`ifdef ECC_DEC_ERR_LOG_EN
  logic         log_valid_reg;
  logic [M-1:0] log_syn_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      log_valid_reg <= 1'b0;
      log_syn_reg   <= '0;
    end else if (clr_cnt_i) begin
      log_valid_reg <= 1'b0;
      log_syn_reg   <= '0;
    end else if (out_hs && db2_reg && !log_valid_reg) begin
      log_valid_reg <= 1'b1;
      log_syn_reg   <= syn2_reg;
    end
  end

  assign log_valid_o    = log_valid_reg;
  assign log_syndrome_o = log_syn_reg;
`endif

endmodule
